// File: rtl/shift_seq_ctrl.sv
// Serializes a parallel word into the shift register, LSB first, for a requested
// bit count, then pulses done. Owns the register's shift enable and serial input.
module shift_seq_ctrl #(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req_data,
    input  logic [CNT_W-1:0] req_len,
    input  logic             hold,
    output logic             sh_en,
    output logic             sh_bit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] FullLen = CNT_W'(N);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // The counter must be able to hold N itself, otherwise a full transfer wraps.
    if ((64'd1 << CNT_W) <= 64'(N)) begin : g_bad_cnt_w
        $error("shift_seq_ctrl: CNT_W too narrow for N");
    end

    state_e           state_q, state_d;
    logic [N-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             last_shift;
    logic [CNT_W-1:0] req_len_eff;

    always_comb begin
        accept      = req_valid && (state_q == StIdle);
        // Zero and oversize lengths both mean a full-width transfer.
        req_len_eff = ((req_len == '0) || (req_len > FullLen)) ? FullLen : req_len;
        last_shift  = (cnt_q == (len_q - CntOne));
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shadow_d = req_data;
                    len_d    = req_len_eff;
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (!hold) begin
                    shadow_d = {1'b0, shadow_q[N-1:1]};
                    cnt_d    = cnt_q + CntOne;
                    if (last_shift) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        sh_en     = (state_q == StShift) && !hold;
        sh_bit    = (state_q == StShift) ? shadow_q[0] : 1'b0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        shift_cnt = cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: expected bits and done latency are queued
// when a request is driven and consumed as the sequencer shifts and finishes.
module tb_shift_seq_ctrl;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 6;

    logic             CLK;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [N-1:0]     req_data;
    logic [CNT_W-1:0] req_len;
    logic             hold;
    logic             sh_en;
    logic             sh_bit;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shift_cnt;

    shift_seq_ctrl #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .hold      (hold),
        .sh_en     (sh_en),
        .sh_bit    (sh_bit),
        .busy      (busy),
        .done      (done),
        .shift_cnt (shift_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic exp_bits[$];
    int   exp_eff[$];
    int   exp_lat[$];
    int   acc_edge    = 0;
    int   prev_acc    = 0;
    int   shifts_seen = 0;
    logic prev_done   = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int eff_len(input logic [CNT_W-1:0] l);
        return ((l == 0) || (l > N)) ? N : int'(l);
    endfunction

    // Number of SHIFT-state cycles when hold is asserted on the cycles set in hm.
    function automatic int calc_lat(input int eff, input logic [63:0] hm);
        int c = 0;
        int s = 0;
        while (s < eff) begin
            c++;
            if (!hm[c]) s++;
        end
        return c;
    endfunction

    task automatic push_expected(input logic [N-1:0] d, input int eff, input int lat);
        for (int i = 0; i < eff; i++) exp_bits.push_back(d[i]);
        exp_eff.push_back(eff);
        exp_lat.push_back(lat);
    endtask

    // Monitor: runs on the falling edge, away from the DUT's active edge.
    always @(negedge CLK) begin
        if (reset_n) begin
            if (hold && busy) check_eq("hold_blocks_sh_en", {31'd0, sh_en}, 32'd0);
            if (req_valid && busy) check_eq("no_ready_while_busy", {31'd0, req_ready}, 32'd0);
            if (sh_en) begin
                if (exp_bits.size() == 0) begin
                    check_eq("sh_en_unexpected", {31'd0, sh_en}, 32'd0);
                end else begin
                    check_eq("sh_bit", {31'd0, sh_bit}, {31'd0, exp_bits.pop_front()});
                    shifts_seen++;
                end
            end
            if (done) begin
                if (exp_lat.size() == 0) begin
                    check_eq("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    int eff;
                    eff = exp_eff.pop_front();
                    check_eq("done_latency", cyc - acc_edge, exp_lat.pop_front());
                    check_eq("shift_total", shifts_seen, eff);
                    check_eq("shift_cnt_done", {26'd0, shift_cnt}, eff);
                    check_eq("bits_left_at_done", exp_bits.size(), 0);
                end
            end
            if (prev_done) check_eq("ready_after_done", {31'd0, req_ready}, 32'd1);
            if (req_valid && req_ready) begin
                prev_acc    = acc_edge;
                acc_edge    = cyc + 1;
                shifts_seen = 0;
            end
        end
        prev_done = done && reset_n;
    end

    task automatic wait_idle();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (!busy) break;
        end
        if (n == 200) check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (req_ready) break;
        end
        if (n == 200) check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic send(input logic [N-1:0] d, input logic [CNT_W-1:0] l, input logic [63:0] hm);
        int eff;
        int lat;
        eff = eff_len(l);
        lat = calc_lat(eff, hm);
        @(posedge CLK);
        #1;
        req_valid = 1'b1;
        req_data  = d;
        req_len   = l;
        push_expected(d, eff, lat);
        wait_ready();
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_data  = $urandom;
        req_len   = CNT_W'($urandom);
        for (int c = 1; c <= lat; c++) begin
            hold = hm[c];
            @(posedge CLK);
            #1;
        end
        hold = 1'b0;
        wait_idle();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_data  = '0;
        req_len   = '0;
        hold      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset_n = 1'b1;
        @(negedge CLK);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_sh_en", {31'd0, sh_en}, 32'd0);
        check_eq("rst_sh_bit", {31'd0, sh_bit}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_shift_cnt", {26'd0, shift_cnt}, 32'd0);

        // Full-width transfer via len=0, then a short one.
        send(32'hAFAFAFAF, 6'd0, 64'd0);
        send(32'h0000000D, 6'd4, 64'd0);

        // Hold on SHIFT cycles 3 and 4 stretches the transfer by two cycles.
        send(32'h000000B6, 6'd8, 64'h18);

        // Oversize length clamps; valid stays high and data churns while busy.
        begin
            logic [N-1:0] b;
            int n;
            b = 32'h00000009;
            @(posedge CLK);
            #1;
            req_valid = 1'b1;
            req_data  = 32'h12345678;
            req_len   = 6'd40;
            push_expected(32'h12345678, 32, 32);
            wait_ready();
            @(posedge CLK);
            #1;
            for (n = 0; n < 60; n++) begin
                if (req_ready) begin
                    req_data = b;
                    req_len  = 6'd4;
                    push_expected(b, 4, 4);
                    break;
                end
                req_data = $urandom;
                req_len  = CNT_W'($urandom);
                @(posedge CLK);
                #1;
            end
            if (n == 60) check_eq("second_accept_timeout", {31'd0, req_ready}, 32'd1);
            @(posedge CLK);
            #1;
            req_valid = 1'b0;
            wait_idle();
            check_eq("accept_spacing", acc_edge - prev_acc, 34);
        end

        // Reset mid-transfer aborts without a done pulse.
        @(posedge CLK);
        #1;
        req_valid = 1'b1;
        req_data  = 32'hC3A5_0F1E;
        req_len   = 6'd0;
        push_expected(32'hC3A5_0F1E, 32, 32);
        wait_ready();
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        reset_n = 1'b0;
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
        exp_bits.delete();
        exp_eff.delete();
        exp_lat.delete();
        check_eq("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("abort_sh_en", {31'd0, sh_en}, 32'd0);
        check_eq("abort_shift_cnt", {26'd0, shift_cnt}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge CLK);

        // A few random transfers with random early holds.
        for (int t = 0; t < 4; t++) begin
            logic [63:0] hm;
            hm = 64'($urandom) & 64'h1F_FFFE;
            send($urandom, CNT_W'($urandom), hm);
        end

        repeat (4) @(posedge CLK);
        check_eq("bits_drained", exp_bits.size(), 0);
        check_eq("dones_drained", exp_lat.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
